keypad_entry_unit: RTL and testbench
====================================

# keypad_entry_unit

Parametrised keypad entry controller that succeeds the fixed 32-bit, 10-digit decimal input unit. It turns debounced `{row,col}` key coordinates from the keypad unit into a decimal operand of configurable width and digit count. It adds press-edge detection, range-checked accumulation, a clear key, a reject indication and optional signed entry. It sits between the keypad unit and the hazard unit, the MEM/WB register and the seven-segment/output units.

## Interface
- `DATA_WIDTH`, 32: width of `keypad_data`; range 8..32.
- `MAX_DIGITS`, 10: maximum accepted decimal digits; range 1..10.
- `clk` input 1: system clock; all state updates on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `key_coord` input 8: `{row_val,col_val}` from keypad unit; 0 = no key.
- `ignore_pause` input 1: from hazard unit; blocks the resume key while UART transfer runs.
- `input_enable` input 1: from data memory; requests a new operand.
- `input_complete` output 1: level, high from Enter until the next accepted request.
- `keypad_data` output DATA_WIDTH: current operand, two's complement when negative.
- `switch_enable` output 1: operand source is the switches.
- `cpu_pause` output 1: user pause active.
- `negative` output 1: sign indicator for the display.
- `digit_count` output $clog2(MAX_DIGITS+1): number of digits entered.
- `entry_full` output 1: `digit_count == MAX_DIGITS`.
- `key_reject` output 1: one-cycle pulse when a press was ignored because of range, digit-limit or sign-flip overflow.

## Operation
- Key map, unchanged: 0=`0111_1101`, 1..9 = rows 1110/1101/1011 × cols 1110/1101/1011, `*`=`0111_1110` backspace, `#`=`0111_1011` enter, A=`1110_0111` pause, B=`1101_0111` switch, C=`1011_0111` clear, D=`0111_0111` sign.
- Press event: `key_coord != 0` and the registered previous `key_coord == 0`. A held key produces exactly one event. Unmapped codes are ignored without a reject.
- States: BLOCK (reset), KEYPAD, SWITCH, PAUSE. `prev_state` holds the state to return to from PAUSE.
- BLOCK: pause event → PAUSE; pause takes priority over `input_enable`. Otherwise `input_enable` → KEYPAD, which clears `input_complete`, magnitude, `digit_count` and `negative`.
- KEYPAD:
  - B → SWITCH, `switch_enable`=1.
  - A → PAUSE, `cpu_pause`=1.
  - `#` → BLOCK, `input_complete`=1, `digit_count`=0. The value and source select are held. Negative zero is forced to `negative`=0.
  - `*`: if count>0, magnitude/=10 and count−1; otherwise no effect.
  - C: magnitude, count and `negative` are set to 0.
  - Digit d: new magnitude = mag×10+d, computed at DATA_WIDTH+4 bits.
    - Accepted if count<MAX_DIGITS and new magnitude ≤ limit. Unsigned limit is 2^W−1. Signed limit is 2^(W−1)−1 when positive and 2^(W−1) when negative.
    - Otherwise `key_reject` pulses and nothing changes.
    - Key 0 with magnitude 0 is ignored and not counted.
- SWITCH: B → KEYPAD with `switch_enable`=0. `#` → as in KEYPAD. A → PAUSE. All other keys are ignored.
- PAUSE: A event with `ignore_pause`=0 → `prev_state`, `cpu_pause`=0. All other events are ignored.
- `keypad_data` = `negative` ? −magnitude : magnitude, truncated to DATA_WIDTH.

## Timing
- Reset values: every output 0, state BLOCK, previous-key register 0.
- One-cycle latency: an event sampled at edge N is visible on outputs after edge N.
- `key_reject` is high for exactly the cycle after the rejecting edge.
- `input_enable` is level-sampled only in BLOCK. A held `input_enable` after Enter starts a new entry on the next cycle; the hazard unit must drop it on `input_complete`.
- `rst_n` asserted mid-entry clears everything immediately. The first press after release needs `key_coord` to return to 0 first only if it was held through reset.

## Configuration
- `KEYPAD_SIGNED_EN` defined: key D toggles `negative` in KEYPAD. Signed limits apply. Flipping to positive when magnitude = 2^(W−1) is rejected with `key_reject`.
- `KEYPAD_SIGNED_EN` undefined: key D is ignored, `negative` is tied 0 and the unsigned limit applies.

## Test plan
- Reset, then `input_enable`, keys 1,2,3, `#` → `keypad_data`=123, `input_complete`=1, state BLOCK, `digit_count`=0.
- `key_coord`=KEY_FIVE held 20 cycles → magnitude 5, `digit_count`=1, exactly one event.
- DATA_WIDTH=8 unsigned: keys 2,5,5 → 255; then 0 → `key_reject` pulse, value stays 255. Then `*` → 25, count 2.
- DATA_WIDTH=8, `KEYPAD_SIGNED_EN`: D, 1,2,8 → `keypad_data`=8'h80, `negative`=1. Then D → reject, still −128.
- MAX_DIGITS=3: keys 1,0,0,0 → 100, 4th digit rejected, `entry_full`=1. Then C → 0, count 0.
- In KEYPAD press A → `cpu_pause`=1. A with `ignore_pause`=1 → still paused. A with `ignore_pause`=0 → back in KEYPAD with digits intact.

Source files
------------

// File: rtl/keypad_entry_unit.sv
// Keypad entry controller: builds a decimal operand from debounced keypad coordinates.
// Optional signed entry (key D toggles sign) is enabled by defining KEYPAD_SIGNED_EN.
module keypad_entry_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      key_coord,
    input  logic                            ignore_pause,
    input  logic                            input_enable,
    output logic                            input_complete,
    output logic [DATA_WIDTH-1:0]           keypad_data,
    output logic                            switch_enable,
    output logic                            cpu_pause,
    output logic                            negative,
    output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count,
    output logic                            entry_full,
    output logic                            key_reject
);

    localparam int EW = DATA_WIDTH + 4;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
`ifdef KEYPAD_SIGNED_EN
    localparam logic [EW-1:0] LIM_POS = (EW'(1) << (DATA_WIDTH - 1)) - EW'(1);
    localparam logic [EW-1:0] LIM_NEG = EW'(1) << (DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MAG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
    localparam logic [EW-1:0] LIM_UNS = (EW'(1) << DATA_WIDTH) - EW'(1);
`endif

    typedef enum logic [1:0] {
        ST_BLOCK  = 2'd0,
        ST_KEYPAD = 2'd1,
        ST_SWITCH = 2'd2,
        ST_PAUSE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        K_NONE   = 3'd0,
        K_DIGIT  = 3'd1,
        K_BACK   = 3'd2,
        K_ENTER  = 3'd3,
        K_PAUSE  = 3'd4,
        K_SWITCH = 3'd5,
        K_CLEAR  = 3'd6,
        K_SIGN   = 3'd7
    } key_e;

    state_e                r_state;
    state_e                r_ret;
    logic [7:0]            r_prev_key;
    logic                  r_armed;
    logic [DATA_WIDTH-1:0] r_mag;
    logic [CW-1:0]         r_count;
    logic                  r_neg;
    logic                  r_complete;
    logic                  r_switch;
    logic                  r_pause;
    logic                  r_reject;

    key_e                  w_kind;
    logic [3:0]            w_digit;
    logic                  w_press;
    logic [EW-1:0]         w_mag_ext;
    logic [EW-1:0]         w_new_mag;
    logic [EW-1:0]         w_limit;
    logic                  w_digit_ok;
    logic                  w_lead_zero;
    logic [DATA_WIDTH-1:0] w_mag_div10;

    // Key code decode into a key class and digit value
    always_comb begin
        w_kind  = K_NONE;
        w_digit = 4'd0;
        case (key_coord)
            8'h7D:   begin w_kind = K_DIGIT; w_digit = 4'd0; end
            8'hEE:   begin w_kind = K_DIGIT; w_digit = 4'd1; end
            8'hED:   begin w_kind = K_DIGIT; w_digit = 4'd2; end
            8'hEB:   begin w_kind = K_DIGIT; w_digit = 4'd3; end
            8'hDE:   begin w_kind = K_DIGIT; w_digit = 4'd4; end
            8'hDD:   begin w_kind = K_DIGIT; w_digit = 4'd5; end
            8'hDB:   begin w_kind = K_DIGIT; w_digit = 4'd6; end
            8'hBE:   begin w_kind = K_DIGIT; w_digit = 4'd7; end
            8'hBD:   begin w_kind = K_DIGIT; w_digit = 4'd8; end
            8'hBB:   begin w_kind = K_DIGIT; w_digit = 4'd9; end
            8'h7E:   w_kind = K_BACK;
            8'h7B:   w_kind = K_ENTER;
            8'hE7:   w_kind = K_PAUSE;
            8'hD7:   w_kind = K_SWITCH;
            8'hB7:   w_kind = K_CLEAR;
            8'h77:   w_kind = K_SIGN;
            default: w_kind = K_NONE;
        endcase
    end

    // Press detection and range-checked digit accumulation (widened so overflow is visible)
    always_comb begin
        w_press     = (key_coord != 8'h00) && (r_prev_key == 8'h00) && r_armed;
        w_mag_ext   = {4'b0000, r_mag};
        w_new_mag   = (w_mag_ext << 3) + (w_mag_ext << 1) + {{(EW-4){1'b0}}, w_digit};
`ifdef KEYPAD_SIGNED_EN
        w_limit     = r_neg ? LIM_NEG : LIM_POS;
`else
        w_limit     = LIM_UNS;
`endif
        w_digit_ok  = (r_count < MAX_CNT) && (w_new_mag <= w_limit);
        w_lead_zero = (w_digit == 4'd0) && (r_mag == {DATA_WIDTH{1'b0}});
        w_mag_div10 = r_mag / DATA_WIDTH'(10);
    end

    // Entry state machine; r_armed keeps a key held through reset from counting as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BLOCK;
            r_ret      <= ST_BLOCK;
            r_prev_key <= 8'h00;
            r_armed    <= 1'b0;
            r_mag      <= {DATA_WIDTH{1'b0}};
            r_count    <= {CW{1'b0}};
            r_neg      <= 1'b0;
            r_complete <= 1'b0;
            r_switch   <= 1'b0;
            r_pause    <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_prev_key <= key_coord;
            if (key_coord == 8'h00) r_armed <= 1'b1;
            r_reject <= 1'b0;
            case (r_state)
                ST_BLOCK: begin
                    if (w_press && (w_kind == K_PAUSE)) begin
                        r_ret   <= ST_BLOCK;
                        r_state <= ST_PAUSE;
                        r_pause <= 1'b1;
                    end else if (input_enable) begin
                        r_state    <= ST_KEYPAD;
                        r_complete <= 1'b0;
                        r_mag      <= {DATA_WIDTH{1'b0}};
                        r_count    <= {CW{1'b0}};
                        r_neg      <= 1'b0;
                    end
                end
                ST_KEYPAD: begin
                    if (w_press) begin
                        case (w_kind)
                            K_SWITCH: begin
                                r_state  <= ST_SWITCH;
                                r_switch <= 1'b1;
                            end
                            K_PAUSE: begin
                                r_ret   <= ST_KEYPAD;
                                r_state <= ST_PAUSE;
                                r_pause <= 1'b1;
                            end
                            K_ENTER: begin
                                r_state    <= ST_BLOCK;
                                r_complete <= 1'b1;
                                r_count    <= {CW{1'b0}};
                                r_neg      <= r_neg & (|r_mag);
                            end
                            K_BACK: begin
                                if (r_count != {CW{1'b0}}) begin
                                    r_mag   <= w_mag_div10;
                                    r_count <= r_count - CW'(1);
                                end
                            end
                            K_CLEAR: begin
                                r_mag   <= {DATA_WIDTH{1'b0}};
                                r_count <= {CW{1'b0}};
                                r_neg   <= 1'b0;
                            end
`ifdef KEYPAD_SIGNED_EN
                            K_SIGN: begin
                                if (r_neg && (r_mag == MAG_MIN)) r_reject <= 1'b1;
                                else r_neg <= ~r_neg;
                            end
`endif
                            K_DIGIT: begin
                                if (!w_lead_zero) begin
                                    if (w_digit_ok) begin
                                        r_mag   <= w_new_mag[DATA_WIDTH-1:0];
                                        r_count <= r_count + CW'(1);
                                    end else begin
                                        r_reject <= 1'b1;
                                    end
                                end
                            end
                            default: r_state <= r_state;
                        endcase
                    end
                end
                ST_SWITCH: begin
                    if (w_press) begin
                        case (w_kind)
                            K_SWITCH: begin
                                r_state  <= ST_KEYPAD;
                                r_switch <= 1'b0;
                            end
                            K_ENTER: begin
                                r_state    <= ST_BLOCK;
                                r_complete <= 1'b1;
                                r_count    <= {CW{1'b0}};
                                r_neg      <= r_neg & (|r_mag);
                            end
                            K_PAUSE: begin
                                r_ret   <= ST_SWITCH;
                                r_state <= ST_PAUSE;
                                r_pause <= 1'b1;
                            end
                            default: r_state <= r_state;
                        endcase
                    end
                end
                ST_PAUSE: begin
                    if (w_press && (w_kind == K_PAUSE) && !ignore_pause) begin
                        r_state <= r_ret;
                        r_pause <= 1'b0;
                    end
                end
                default: r_state <= ST_BLOCK;
            endcase
        end
    end

    assign keypad_data    = r_neg ? (DATA_WIDTH'(0) - r_mag) : r_mag;
    assign input_complete = r_complete;
    assign switch_enable  = r_switch;
    assign cpu_pause      = r_pause;
    assign negative       = r_neg;
    assign digit_count    = r_count;
    assign entry_full     = (r_count == MAX_CNT);
    assign key_reject     = r_reject;

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Self-checking bench for keypad_entry_unit: three configurations share one stimulus stream
// and are compared against a behavioural model, plus directed scenarios.
module tb_keypad_entry_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ignore_pause;
    logic       input_enable;
    logic [7:0] key_coord;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    localparam logic [7:0] KY_0 = 8'h7D, KY_1 = 8'hEE, KY_2 = 8'hED, KY_3 = 8'hEB;
    localparam logic [7:0] KY_4 = 8'hDE, KY_5 = 8'hDD, KY_7 = 8'hBE, KY_8 = 8'hBD;
    localparam logic [7:0] KY_9 = 8'hBB, KY_STAR = 8'h7E, KY_HASH = 8'h7B, KY_A = 8'hE7;
    localparam logic [7:0] KY_B = 8'hD7, KY_C = 8'hB7, KY_D = 8'h77;
`ifdef KEYPAD_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    // instance a: 32 bits / 10 digits, b: 8 bits / 10 digits, c: 32 bits / 3 digits
    logic ic_a, sw_a, cp_a, ng_a, ef_a, rj_a; logic [31:0] d_a; logic [3:0] c_a;
    logic ic_b, sw_b, cp_b, ng_b, ef_b, rj_b; logic [7:0]  d_b; logic [3:0] c_b;
    logic ic_c, sw_c, cp_c, ng_c, ef_c, rj_c; logic [31:0] d_c; logic [1:0] c_c;

    keypad_entry_unit #(.DATA_WIDTH(32), .MAX_DIGITS(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .ignore_pause(ignore_pause),
        .input_enable(input_enable), .input_complete(ic_a), .keypad_data(d_a),
        .switch_enable(sw_a), .cpu_pause(cp_a), .negative(ng_a), .digit_count(c_a),
        .entry_full(ef_a), .key_reject(rj_a));
    keypad_entry_unit #(.DATA_WIDTH(8), .MAX_DIGITS(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .ignore_pause(ignore_pause),
        .input_enable(input_enable), .input_complete(ic_b), .keypad_data(d_b),
        .switch_enable(sw_b), .cpu_pause(cp_b), .negative(ng_b), .digit_count(c_b),
        .entry_full(ef_b), .key_reject(rj_b));
    keypad_entry_unit #(.DATA_WIDTH(32), .MAX_DIGITS(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .ignore_pause(ignore_pause),
        .input_enable(input_enable), .input_complete(ic_c), .keypad_data(d_c),
        .switch_enable(sw_c), .cpu_pause(cp_c), .negative(ng_c), .digit_count(c_c),
        .entry_full(ef_c), .key_reject(rj_c));

    logic [41:0] obs [3];
    assign obs[0] = {ic_a, sw_a, cp_a, ng_a, ef_a, rj_a, c_a, d_a};
    assign obs[1] = {ic_b, sw_b, cp_b, ng_b, ef_b, rj_b, c_b, 24'h000000, d_b};
    assign obs[2] = {ic_c, sw_c, cp_c, ng_c, ef_c, rj_c, 2'b00, c_c, d_c};

    // ---------------- behavioural reference model ----------------
    localparam int S_BLOCK = 0, S_KEYPAD = 1, S_SWITCH = 2, S_PAUSE = 3;
    localparam int K_STAR = 10, K_HASH = 11, K_A = 12, K_B = 13, K_C = 14, K_D = 15;
    logic [7:0] keys [16] = '{8'h7D, 8'hEE, 8'hED, 8'hEB, 8'hDE, 8'hDD, 8'hDB, 8'hBE,
                              8'hBD, 8'hBB, 8'h7E, 8'h7B, 8'hE7, 8'hD7, 8'hB7, 8'h77};
    int w_tab [3]  = '{32, 8, 32};
    int md_tab [3] = '{10, 10, 3};

    typedef struct {
        int st; int ret; longint mag; int cnt;
        bit neg; bit comp; bit sw; bit ps; bit rej;
    } mdl_t;

    mdl_t       mdl [3];
    logic [7:0] last_key;
    bit         armed;

    function automatic int decode(logic [7:0] c);
        for (int i = 0; i < 16; i++) if (keys[i] == c) return i;
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t m, int k, bit ev, bit ie, bit ip, int w, int md);
        longint one = 1;
        longint lim;
        longint nm;
        m.rej = 1'b0;
        if (m.st == S_BLOCK) begin
            if (ev && k == K_A) begin m.ret = S_BLOCK; m.st = S_PAUSE; m.ps = 1'b1; end
            else if (ie) begin m.st = S_KEYPAD; m.comp = 0; m.mag = 0; m.cnt = 0; m.neg = 0; end
        end else if (m.st == S_PAUSE) begin
            if (ev && k == K_A && !ip) begin m.st = m.ret; m.ps = 1'b0; end
        end else if (ev) begin
            if (k == K_HASH) begin
                m.st = S_BLOCK; m.comp = 1'b1; m.cnt = 0;
                if (m.mag == 0) m.neg = 1'b0;
            end else if (k == K_A) begin
                m.ret = m.st; m.st = S_PAUSE; m.ps = 1'b1;
            end else if (k == K_B) begin
                m.sw = (m.st == S_KEYPAD);
                m.st = m.sw ? S_SWITCH : S_KEYPAD;
            end else if (m.st == S_KEYPAD) begin
                if (k == K_STAR) begin
                    if (m.cnt > 0) begin m.mag = m.mag / 10; m.cnt = m.cnt - 1; end
                end else if (k == K_C) begin
                    m.mag = 0; m.cnt = 0; m.neg = 1'b0;
                end else if (k == K_D) begin
                    if (SGN) begin
                        if (m.neg && m.mag == (one << (w - 1))) m.rej = 1'b1;
                        else m.neg = !m.neg;
                    end
                end else if (k >= 0 && k <= 9 && !(k == 0 && m.mag == 0)) begin
                    if (SGN) lim = m.neg ? (one << (w - 1)) : (one << (w - 1)) - 1;
                    else lim = (one << w) - 1;
                    nm = m.mag * 10 + k;
                    if (m.cnt < md && nm <= lim) begin m.mag = nm; m.cnt = m.cnt + 1; end
                    else m.rej = 1'b1;
                end
            end
        end
        return m;
    endfunction

    function automatic logic [41:0] expv(mdl_t m, int w, int md);
        longint modv = longint'(1) << w;
        longint d    = m.neg ? (modv - m.mag) % modv : m.mag;
        logic [31:0] d32 = d[31:0];
        return {m.comp, m.sw, m.ps, m.neg, (m.cnt == md), m.rej, 4'(m.cnt), d32};
    endfunction

    // Model advances on the same edges as the DUTs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mdl[i] <= '{default: 0};
            last_key <= 8'h00;
            armed    <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++)
                mdl[i] <= step(mdl[i], decode(key_coord),
                               (key_coord != 8'h00) && (last_key == 8'h00) && armed,
                               input_enable, ignore_pause, w_tab[i], md_tab[i]);
            last_key <= key_coord;
            if (key_coord == 8'h00) armed <= 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; key_coord = 8'h00; input_enable = 1'b0; ignore_pause = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic press(input logic [7:0] k);
        key_coord = k; tick();
        key_coord = 8'h00; tick();
    endtask

    task automatic start_entry;
        input_enable = 1'b1; tick();
        input_enable = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0; key_coord = 8'h00; input_enable = 1'b0; ignore_pause = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== 42'h0) begin bad++; $display("FAIL reset_inst%0d act=%h exp=0", i, obs[i]); end
        end
        rst_n = 1'b1; tick();
        start_entry(); press(KY_7);
        total++;
        if (d_a !== 32'd7) begin bad++; $display("FAIL reset_pre_data act=%0d exp=7", d_a); end
        rst_n = 1'b0; #1;
        total++;
        if (obs[0] !== 42'h0) begin bad++; $display("FAIL reset_async act=%h exp=0", obs[0]); end
        rst_n = 1'b1; tick();
    endtask

    task automatic test_basic_entry;
        do_reset(); start_entry();
        press(KY_1); press(KY_2); press(KY_3);
        total++;
        if (d_a !== 32'd123 || c_a !== 4'd3) begin bad++; $display("FAIL basic_pre act=%0d/%0d exp=123/3", d_a, c_a); end
        press(KY_HASH);
        total++;
        if (d_a !== 32'd123 || ic_a !== 1'b1 || c_a !== 4'd0) begin
            bad++; $display("FAIL basic_enter act=%0d/%0b/%0d exp=123/1/0", d_a, ic_a, c_a);
        end
        press(KY_4);
        total++;
        if (d_a !== 32'd123 || ic_a !== 1'b1) begin bad++; $display("FAIL basic_block act=%0d/%0b exp=123/1", d_a, ic_a); end
    endtask

    task automatic test_held_key;
        do_reset(); start_entry();
        key_coord = KY_5;
        repeat (20) tick();
        key_coord = 8'h00; tick();
        total++;
        if (d_a !== 32'd5 || c_a !== 4'd1) begin bad++; $display("FAIL held_key act=%0d/%0d exp=5/1", d_a, c_a); end
    endtask

`ifdef KEYPAD_SIGNED_EN
    task automatic test_signed_w8;
        do_reset(); start_entry();
        press(KY_D); press(KY_1); press(KY_2); press(KY_8);
        total++;
        if (d_b !== 8'h80 || ng_b !== 1'b1) begin bad++; $display("FAIL sgn_min act=%h/%0b exp=80/1", d_b, ng_b); end
        total++;
        if (d_a !== 32'hFFFFFF80) begin bad++; $display("FAIL sgn_w32 act=%h exp=ffffff80", d_a); end
        key_coord = KY_D; tick();
        total++;
        if (rj_b !== 1'b1 || rj_a !== 1'b0) begin bad++; $display("FAIL sgn_flip_rej act=%0b/%0b exp=1/0", rj_b, rj_a); end
        total++;
        if (d_b !== 8'h80 || ng_b !== 1'b1) begin bad++; $display("FAIL sgn_hold act=%h/%0b exp=80/1", d_b, ng_b); end
        key_coord = 8'h00; tick();
        total++;
        if (rj_b !== 1'b0 || ng_a !== 1'b0 || d_a !== 32'd128) begin
            bad++; $display("FAIL sgn_after act=%0b/%0b/%0d exp=0/0/128", rj_b, ng_a, d_a);
        end
    endtask
`else
    task automatic test_unsigned_w8;
        do_reset(); start_entry();
        press(KY_2); press(KY_5); press(KY_5);
        total++;
        if (d_b !== 8'd255 || c_b !== 4'd3) begin bad++; $display("FAIL w8_max act=%0d/%0d exp=255/3", d_b, c_b); end
        key_coord = KY_0; tick();
        total++;
        if (rj_b !== 1'b1 || d_b !== 8'd255) begin bad++; $display("FAIL w8_rej act=%0b/%0d exp=1/255", rj_b, d_b); end
        total++;
        if (rj_a !== 1'b0 || d_a !== 32'd2550) begin bad++; $display("FAIL w32_acc act=%0b/%0d exp=0/2550", rj_a, d_a); end
        key_coord = 8'h00; tick();
        total++;
        if (rj_b !== 1'b0) begin bad++; $display("FAIL w8_rej_pulse act=%0b exp=0", rj_b); end
        press(KY_STAR);
        total++;
        if (d_b !== 8'd25 || c_b !== 4'd2) begin bad++; $display("FAIL w8_back act=%0d/%0d exp=25/2", d_b, c_b); end
        press(KY_D);
        total++;
        if (ng_b !== 1'b0 || d_b !== 8'd25) begin bad++; $display("FAIL w8_d_ignored act=%0b/%0d exp=0/25", ng_b, d_b); end
    endtask
`endif

    task automatic test_max_digits;
        do_reset(); start_entry();
        key_coord = KY_0; tick();
        total++;
        if (rj_c !== 1'b0 || c_c !== 2'd0) begin bad++; $display("FAIL md_lead0 act=%0b/%0d exp=0/0", rj_c, c_c); end
        key_coord = 8'h00; tick();
        press(KY_1); press(KY_0); press(KY_0);
        total++;
        if (d_c !== 32'd100 || ef_c !== 1'b1 || c_c !== 2'd3) begin
            bad++; $display("FAIL md_full act=%0d/%0b/%0d exp=100/1/3", d_c, ef_c, c_c);
        end
        key_coord = KY_0; tick();
        total++;
        if (rj_c !== 1'b1 || d_c !== 32'd100) begin bad++; $display("FAIL md_rej act=%0b/%0d exp=1/100", rj_c, d_c); end
        key_coord = 8'h00; tick();
        press(KY_C);
        total++;
        if (d_c !== 32'd0 || c_c !== 2'd0 || ef_c !== 1'b0) begin
            bad++; $display("FAIL md_clear act=%0d/%0d/%0b exp=0/0/0", d_c, c_c, ef_c);
        end
    endtask

    task automatic test_pause;
        do_reset();
        input_enable = 1'b1; key_coord = KY_A; tick();
        total++;
        if (cp_a !== 1'b1) begin bad++; $display("FAIL pause_prio act=%0b exp=1", cp_a); end
        do_reset(); start_entry();
        press(KY_4); press(KY_2); press(KY_A);
        total++;
        if (cp_a !== 1'b1) begin bad++; $display("FAIL pause_on act=%0b exp=1", cp_a); end
        ignore_pause = 1'b1; press(KY_A);
        total++;
        if (cp_a !== 1'b1) begin bad++; $display("FAIL pause_ignore act=%0b exp=1", cp_a); end
        press(KY_7);
        total++;
        if (d_a !== 32'd42) begin bad++; $display("FAIL pause_digit act=%0d exp=42", d_a); end
        ignore_pause = 1'b0; press(KY_A);
        total++;
        if (cp_a !== 1'b0) begin bad++; $display("FAIL pause_off act=%0b exp=0", cp_a); end
        press(KY_1);
        total++;
        if (d_a !== 32'd421 || c_a !== 4'd3) begin bad++; $display("FAIL pause_resume act=%0d/%0d exp=421/3", d_a, c_a); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        input_enable = 1'b1; tick();
        press(KY_9);
        key_coord = KY_HASH; tick();
        total++;
        if (ic_a !== 1'b1 || d_a !== 32'd9) begin bad++; $display("FAIL b2b_enter act=%0b/%0d exp=1/9", ic_a, d_a); end
        key_coord = 8'h00; tick();
        total++;
        if (ic_a !== 1'b0 || d_a !== 32'd0) begin bad++; $display("FAIL b2b_restart act=%0b/%0d exp=0/0", ic_a, d_a); end
        input_enable = 1'b0;
    endtask

    task automatic test_held_through_reset;
        rst_n = 1'b0; key_coord = KY_A; input_enable = 1'b0; ignore_pause = 1'b0;
        tick(); tick();
        rst_n = 1'b1; tick(); tick();
        total++;
        if (cp_a !== 1'b0) begin bad++; $display("FAIL rst_held act=%0b exp=0", cp_a); end
        key_coord = 8'h00; tick();
        press(KY_A);
        total++;
        if (cp_a !== 1'b1) begin bad++; $display("FAIL rst_repress act=%0b exp=1", cp_a); end
        press(KY_A);
        total++;
        if (cp_a !== 1'b0) begin bad++; $display("FAIL rst_resume act=%0b exp=0", cp_a); end
    endtask

    task automatic test_switch;
        do_reset(); start_entry();
        press(KY_3); press(KY_B);
        total++;
        if (sw_a !== 1'b1) begin bad++; $display("FAIL sw_on act=%0b exp=1", sw_a); end
        press(KY_4);
        total++;
        if (d_a !== 32'd3) begin bad++; $display("FAIL sw_digit act=%0d exp=3", d_a); end
        press(KY_HASH);
        total++;
        if (ic_a !== 1'b1 || sw_a !== 1'b1 || d_a !== 32'd3) begin
            bad++; $display("FAIL sw_enter act=%0b/%0b/%0d exp=1/1/3", ic_a, sw_a, d_a);
        end
    endtask

    task automatic test_random;
        int r;
        int hold;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4) key_coord = 8'h00;
            else if (r < 7) key_coord = keys[$urandom_range(0, 9)];
            else if (r < 9) key_coord = keys[$urandom_range(10, 15)];
            else key_coord = 8'($urandom);
            input_enable = ($urandom_range(0, 7) == 0);
            ignore_pause = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (obs[i] !== expv(mdl[i], w_tab[i], md_tab[i])) begin
                        bad++;
                        $display("FAIL rand_inst%0d cyc=%0d act=%h exp=%h", i, n, obs[i],
                                 expv(mdl[i], w_tab[i], md_tab[i]));
                    end
                end
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_held_key();
`ifdef KEYPAD_SIGNED_EN
        test_signed_w8();
`else
        test_unsigned_w8();
`endif
        test_max_digits();
        test_pause();
        test_back_to_back();
        test_held_through_reset();
        test_switch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
